// File: rtl/bitlet_pkg.sv
// bitlet_pkg
//   Shared constants for the Bitlet datapath blocks.
//   WID_ACC mirrors the `Wid_acc accumulator width used by the Bitlet
//   calculator. WID_OUT is the default requantized width. The saturation
//   bounds are given both as defaults and as helpers for other widths.
//   No ports (package).
package bitlet_pkg;

   localparam int WID_ACC = 32;
   localparam int WID_OUT = 8;

   localparam int SAT_MAX = (1 << (WID_OUT - 1)) - 1;
   localparam int SAT_MIN = -(1 << (WID_OUT - 1));

   // Largest signed value representable in w bits.
   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Smallest signed value representable in w bits.
   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/bitlet_sync_fifo.sv
// bitlet_sync_fifo
//   Single-clock show-ahead FIFO. The head entry is visible on rdata_o
//   whenever empty_o is low, and reads as zero when the FIFO is empty.
//   A push into a full FIFO is accepted only if a pop happens in the same
//   cycle; otherwise it is ignored (the caller flags the drop).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i, wdata_i write request and data
//   pop_i           consume the head entry
//   rdata_o         head entry (show-ahead)
//   full_o, empty_o occupancy flags
module bitlet_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);

   // A pop frees the slot the simultaneous push needs, so full does not
   // block a push when a pop happens in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: it is only ever read through a valid pointer.
   always_ff @(posedge clk) begin
      if (!rst && do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/bitlet_requant_packer.sv
// bitlet_requant_packer
//   Requantizes signed accumulator results to WID_OUT bits and packs
//   N_PACK of them per output word, lane 0 in the LSBs.
//   Pipeline: stage 1 adds bias (no wrap), stage 2 rounds, applies ReLU,
//   shifts and saturates, the packer fills lanes and pushes completed or
//   flushed words into a show-ahead FIFO.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_shift, cfg_relu requantization shift and ReLU enable (stage 2)
//   flush               push a partially filled word once in-flight data lands
//   Aacc_vld, Aacc, bias accumulator result and bias (no backpressure)
//   out_vld, out_rdy    output handshake
//   out_word, out_cnt   packed lanes and number of valid lanes
//   overflow            sticky: a word was dropped at a full FIFO
//   busy                anything in flight, in the packer or queued
//
// Output handshake: a word transfers on a rising edge where out_vld and
// out_rdy are both high. While out_vld is high and out_rdy is low,
// out_word and out_cnt hold their value. out_vld does not depend on
// out_rdy.
module bitlet_requant_packer #(
   parameter int WID_ACC    = bitlet_pkg::WID_ACC,
   parameter int WID_OUT    = bitlet_pkg::WID_OUT,
   parameter int N_PACK     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [4:0]                  cfg_shift,
   input  logic                        cfg_relu,
   input  logic                        flush,
   input  logic                        Aacc_vld,
   input  logic [WID_ACC-1:0]          Aacc,
   input  logic [WID_ACC-1:0]          bias,
   output logic                        out_vld,
   input  logic                        out_rdy,
   output logic [N_PACK*WID_OUT-1:0]   out_word,
   output logic [$clog2(N_PACK):0]     out_cnt,
   output logic                        overflow,
   output logic                        busy
);

   import bitlet_pkg::*;

   localparam int LW = $clog2(N_PACK);
   localparam int CW = LW + 1;
   localparam int OW = N_PACK * WID_OUT;
   localparam int FW = OW + CW;
   // One extra bit over the biased sum so adding the rounding term cannot wrap.
   localparam int SW = WID_ACC + 2;

   localparam logic signed [SW-1:0] SAT_HI = SW'(sat_max(WID_OUT));
   localparam logic signed [SW-1:0] SAT_LO = SW'(sat_min(WID_OUT));

   // Stage 1: biased sum
   logic                      s1_vld_q, s1_flush_q;
   logic signed [WID_ACC:0]   s1_sum_q, s1_sum_d;

   // Stage 2: requantized result
   logic                      s2_vld_q, s2_flush_q;
   logic [WID_OUT-1:0]        s2_res_q, s2_res_d;
   logic signed [SW-1:0]      s2_ext, s2_rnd, s2_tmp, s2_shf;

   // Packer
   logic [OW-1:0]             lanes_q, lanes_d, lanes_wr;
   logic [LW-1:0]             lane_idx_q, lane_idx_d;
   logic [CW-1:0]             cnt_after;
   logic                      word_full, push;
   logic [FW-1:0]             push_data;

   // FIFO side
   logic                      fifo_full, fifo_empty, pop;
   logic [FW-1:0]             fifo_rdata;
   logic                      overflow_q, overflow_d;

   assign s1_sum_d = {Aacc[WID_ACC-1], Aacc} + {bias[WID_ACC-1], bias};

   always_comb begin
      s2_ext = {s1_sum_q[WID_ACC], s1_sum_q};
      s2_rnd = '0;
      if (cfg_shift != 5'd0) s2_rnd = SW'(1) << (cfg_shift - 5'd1);
      s2_tmp = s2_ext + s2_rnd;
      if (cfg_relu && s2_tmp[SW-1]) s2_tmp = '0;
      s2_shf = s2_tmp >>> cfg_shift;
      if (s2_shf > SAT_HI)      s2_res_d = SAT_HI[WID_OUT-1:0];
      else if (s2_shf < SAT_LO) s2_res_d = SAT_LO[WID_OUT-1:0];
      else                      s2_res_d = s2_shf[WID_OUT-1:0];
   end

   // The flush request travels down the pipeline beside the data so that a
   // flush only closes the word after every result issued before it has
   // landed, and results issued after it start a fresh word.
   always_comb begin
      lanes_wr = lanes_q;
      if (s2_vld_q) lanes_wr[int'(lane_idx_q)*WID_OUT +: WID_OUT] = s2_res_q;
      cnt_after = {1'b0, lane_idx_q} + CW'(s2_vld_q);
      word_full = s2_vld_q && (lane_idx_q == LW'(N_PACK - 1));
      push      = word_full || (s2_flush_q && (cnt_after != '0));
      push_data = {cnt_after, lanes_wr};
      if (push) begin
         lanes_d    = '0;
         lane_idx_d = '0;
      end else begin
         lanes_d    = lanes_wr;
         lane_idx_d = lane_idx_q + LW'(s2_vld_q);
      end
   end

   assign pop        = out_vld && out_rdy;
   assign overflow_d = overflow_q || (push && fifo_full && !pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q   <= 1'b0;
         s1_flush_q <= 1'b0;
         s1_sum_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_flush_q <= 1'b0;
         s2_res_q   <= '0;
         lanes_q    <= '0;
         lane_idx_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         s1_vld_q   <= Aacc_vld;
         s1_flush_q <= flush;
         if (Aacc_vld) s1_sum_q <= s1_sum_d;
         s2_vld_q   <= s1_vld_q;
         s2_flush_q <= s1_flush_q;
         if (s1_vld_q) s2_res_q <= s2_res_d;
         lanes_q    <= lanes_d;
         lane_idx_q <= lane_idx_d;
         overflow_q <= overflow_d;
      end
   end

   bitlet_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (push_data),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_vld  = !fifo_empty;
   assign out_word = fifo_rdata[OW-1:0];
   assign out_cnt  = fifo_rdata[FW-1:OW];
   assign overflow = overflow_q;
   assign busy     = s1_vld_q || s2_vld_q || s1_flush_q || s2_flush_q ||
                     (lane_idx_q != '0) || !fifo_empty;

endmodule

// File: tb/tb_bitlet_requant_packer.sv
module tb_bitlet_requant_packer;

   localparam int WA = 32;
   localparam int OW = 32;
   localparam int CW = 3;
   localparam int W  = OW + CW;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    cfg_shift;
   logic          cfg_relu;
   logic          flush;
   logic          Aacc_vld;
   logic [WA-1:0] Aacc;
   logic [WA-1:0] bias;
   logic          out_vld;
   logic          out_rdy;
   logic [OW-1:0] out_word;
   logic [CW-1:0] out_cnt;
   logic          overflow;
   logic          busy;

   always #5 clk = ~clk;

   bitlet_requant_packer #(
      .WID_ACC    (WA),
      .WID_OUT    (8),
      .N_PACK     (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_shift (cfg_shift),
      .cfg_relu  (cfg_relu),
      .flush     (flush),
      .Aacc_vld  (Aacc_vld),
      .Aacc      (Aacc),
      .bias      (bias),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out_word  (out_word),
      .out_cnt   (out_cnt),
      .overflow  (overflow),
      .busy      (busy)
   );

   // ---------------- scoreboard ----------------
   int            n_vec = 0;
   int            n_err = 0;
   logic [W-1:0]  exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Every word leaving the DUT is compared against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_vld && out_rdy) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_word: got cnt=%0d word=%h, required none", out_cnt, out_word);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if ({out_cnt, out_word} !== e) begin
               n_err++;
               $display("FAIL word_out: got cnt=%0d word=%h, required cnt=%0d word=%h",
                        out_cnt, out_word, e[W-1:OW], e[OW-1:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      Aacc_vld = 1'b0;
      flush = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [WA-1:0] a, input logic [WA-1:0] b);
      Aacc_vld = 1'b1;
      Aacc = a;
      bias = b;
      tick();
      Aacc_vld = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 100 && (busy || out_vld); k++) tick();
      check({name, "_idle"}, {63'd0, busy}, 64'd0);
   endtask

   // Word of four consecutive byte values base, base+1, ... (lane 0 = base).
   function automatic logic [OW-1:0] mkword(input int base);
      return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_out_vld"},  {63'd0, out_vld}, 64'd0);
      check({tag, "_out_word"}, {32'd0, out_word}, 64'd0);
      check({tag, "_out_cnt"},  {61'd0, out_cnt}, 64'd0);
      check({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
      check({tag, "_busy"},     {63'd0, busy}, 64'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [WA-1:0] a;
      logic [WA-1:0] b;
      logic [4:0]    sh;
      logic          relu;
      logic [7:0]    exp;
   } vec_t;

   vec_t vt[13];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // a, bias, shift, relu -> expected 8-bit lane
      vt[0]  = '{32'd23,          32'd0,          5'd1,  1'b0, 8'h0C}; // 24>>>1
      vt[1]  = '{32'd1000000,     32'd0,          5'd0,  1'b0, 8'h7F}; // sat high
      vt[2]  = '{-32'sd1000000,   32'd0,          5'd0,  1'b0, 8'h80}; // sat low
      vt[3]  = '{-32'sd1000000,   32'd0,          5'd0,  1'b1, 8'h00}; // relu
      vt[4]  = '{32'd1000,        32'd24,         5'd4,  1'b0, 8'h40}; // 1032>>>4
      vt[5]  = '{-32'sd5,         32'd0,          5'd1,  1'b0, 8'hFE}; // -4>>>1
      vt[6]  = '{-32'sd6,         32'd0,          5'd2,  1'b0, 8'hFF}; // -4>>>2
      vt[7]  = '{32'd100,         -32'sd50,       5'd0,  1'b0, 8'h32}; // 50
      vt[8]  = '{32'h7FFFFFFF,    32'h7FFFFFFF,   5'd31, 1'b0, 8'h02}; // no wrap
      vt[9]  = '{32'h80000000,    32'h80000000,   5'd31, 1'b0, 8'hFE}; // -1.5 -> -2
      vt[10] = '{-32'sd3,         32'd0,          5'd2,  1'b1, 8'h00}; // relu after round
      vt[11] = '{32'd300,         32'd0,          5'd1,  1'b0, 8'h7F}; // 150 -> sat
      vt[12] = '{-32'sd7,         32'd0,          5'd1,  1'b0, 8'hFD}; // -6>>>1

      rst = 1'b1;
      cfg_shift = 5'd0;
      cfg_relu = 1'b0;
      flush = 1'b0;
      Aacc_vld = 1'b0;
      Aacc = '0;
      bias = '0;
      out_rdy = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_idle_outputs("reset");

      // Table: each vector becomes a one-lane flushed word.
      for (int i = 0; i < 13; i++) begin
         cfg_shift = vt[i].sh;
         cfg_relu  = vt[i].relu;
         exp_q.push_back({3'd1, 24'd0, vt[i].exp});
         send(vt[i].a, vt[i].b);
         pulse_flush();
         wait_idle($sformatf("vec%0d", i));
      end

      // Full word and latency: out_vld appears three cycles after the 4th input.
      cfg_shift = 5'd4;
      cfg_relu = 1'b0;
      exp_q.push_back({3'd4, 32'h40404040});
      for (int i = 0; i < 4; i++) send(32'd1000, 32'd24);
      tick();
      check("latency_t2_no_vld", {63'd0, out_vld}, 64'd0);
      tick();
      check("latency_t3_vld", {63'd0, out_vld}, 64'd1);
      wait_idle("basic");

      // Partial flush of three lanes, then a flush with nothing to emit.
      cfg_shift = 5'd0;
      exp_q.push_back({3'd3, 32'h00030201});
      send(32'd1, 32'd0);
      send(32'd2, 32'd0);
      send(32'd3, 32'd0);
      pulse_flush();
      wait_idle("partial");
      pulse_flush();
      repeat (5) tick();
      check("empty_flush_no_word", {63'd0, out_vld}, 64'd0);
      check("empty_flush_busy", {63'd0, busy}, 64'd0);

      // Backpressure: five words into a four-deep FIFO.
      out_rdy = 1'b0;
      for (int i = 1; i <= 20; i++) send(32'(i), 32'd0);
      repeat (4) tick();
      check("bp_overflow", {63'd0, overflow}, 64'd1);
      check("bp_out_vld", {63'd0, out_vld}, 64'd1);
      check("bp_head_word", {32'd0, out_word}, {32'd0, mkword(1)});
      check("bp_head_cnt", {61'd0, out_cnt}, 64'd4);
      repeat (3) tick();
      check("bp_head_stable", {32'd0, out_word}, {32'd0, mkword(1)});
      for (int k = 0; k < 4; k++) exp_q.push_back({3'd4, mkword(4 * k + 1)});
      out_rdy = 1'b1;
      wait_idle("bp_drain");
      check("bp_overflow_sticky", {63'd0, overflow}, 64'd1);
      do_reset();
      check("bp_overflow_cleared", {63'd0, overflow}, 64'd0);

      // Full FIFO: the fifth push coincides with a pop and must not be dropped.
      out_rdy = 1'b0;
      for (int i = 1; i <= 16; i++) send(32'(i), 32'd0);
      tick();
      tick();
      check("full_out_vld", {63'd0, out_vld}, 64'd1);
      for (int k = 0; k < 5; k++) exp_q.push_back({3'd4, mkword(4 * k + 1)});
      for (int i = 17; i <= 20; i++) send(32'(i), 32'd0);
      tick();
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      check("pushpop_overflow", {63'd0, overflow}, 64'd0);
      check("pushpop_head", {32'd0, out_word}, {32'd0, mkword(5)});
      out_rdy = 1'b1;
      wait_idle("pushpop_drain");
      check("pushpop_overflow_end", {63'd0, overflow}, 64'd0);

      // Reset mid-stream discards in-flight data; next word starts at lane 0.
      send(32'd9, 32'd0);
      send(32'd8, 32'd0);
      do_reset();
      check_idle_outputs("midreset");
      exp_q.push_back({3'd4, 32'h08070605});
      for (int i = 5; i <= 8; i++) send(32'(i), 32'd0);
      wait_idle("midreset_word");

      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
